player2_ai_ctrl: RTL

- Computer-controlled opponent for the right half of the court.
- Consumes the ball position from ball_pos_ctrl and the vsync strobe from vga_timing; advances once per video frame.
- Produces player 2's xpos/ypos, which drive Player_2 and the pl2_posx/pl2_posy inputs of ball_pos_ctrl. This replaces the current constants 800/680.
- Motion: walks toward the ball's landing side and jumps with simple integer gravity.

---
 rtl/bv_ai_pkg.sv | 21 ++
 rtl/vsync_edge_det.sv | 21 ++
 rtl/player2_ai_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bv_ai_pkg.sv
// Shared definitions for the volleyball AI blocks: jump state encoding,
// position width and the jitter LFSR seed/taps.
package bv_ai_pkg;

    localparam int POS_W = 12;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } jump_state_e;

    // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/vsync_edge_det.sv
// Rising-edge detector on vsync: produces a one-cycle frame tick.
module vsync_edge_det (
    input  logic pclk_i,
    input  logic rst_ni,
    input  logic vsync_i,
    output logic tick_o
);

    logic vsync_q;

    always_ff @(posedge pclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync_i;
        end
    end

    assign tick_o = vsync_i & ~vsync_q;

endmodule

// File: rtl/player2_ai_ctrl.sv
// Computer-controlled player 2: tracks the ball once per frame and jumps with
// integer gravity. Define AI_JITTER_EN to add LFSR noise to the aim point.
module player2_ai_ctrl
    import bv_ai_pkg::*;
#(
    parameter int HOME_X     = 800,
    parameter int GROUND_Y   = 680,
    parameter int NET_X      = 512,
    parameter int X_MIN      = 530,
    parameter int X_MAX      = 960,
    parameter int STEP       = 6,
    parameter int AIM_OFFSET = 16,
    parameter int JUMP_V     = 20,
    parameter int GRAVITY    = 1,
    parameter int JUMP_DX    = 60,
    parameter int JUMP_Y_HI  = 300,
    parameter int JUMP_Y_LO  = 500
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             vsync,
    input  logic             enable,
    input  logic [POS_W-1:0] ball_xpos,
    input  logic [POS_W-1:0] ball_ypos,
    output logic [POS_W-1:0] xpos,
    output logic [POS_W-1:0] ypos,
    output logic             in_air
);

    localparam logic [POS_W-1:0] HOME_XL   = POS_W'(HOME_X);
    localparam logic [POS_W-1:0] GROUND_YL = POS_W'(GROUND_Y);
    localparam logic [POS_W-1:0] NET_XL    = POS_W'(NET_X);
    localparam logic [POS_W-1:0] JUMP_VL   = POS_W'(JUMP_V);
    localparam logic [POS_W-1:0] GRAVITYL  = POS_W'(GRAVITY);
    localparam logic [POS_W-1:0] JUMP_DXL  = POS_W'(JUMP_DX);
    localparam logic [POS_W-1:0] Y_HIL     = POS_W'(JUMP_Y_HI);
    localparam logic [POS_W-1:0] Y_LOL     = POS_W'(JUMP_Y_LO);
    localparam logic [POS_W:0]   STEPL     = (POS_W+1)'(STEP);

    function automatic logic [POS_W-1:0] clamp_x(input logic signed [POS_W+1:0] v);
        if (v < (POS_W+2)'(X_MIN)) return POS_W'(X_MIN);
        if (v > (POS_W+2)'(X_MAX)) return POS_W'(X_MAX);
        return POS_W'(v);
    endfunction

    logic tick;

    vsync_edge_det u_vsync_edge (
        .pclk_i (pclk),
        .rst_ni (rst),
        .vsync_i(vsync),
        .tick_o (tick)
    );

    jump_state_e              state_q, state_d;
    logic [POS_W-1:0]         xpos_q, xpos_d;
    logic [POS_W-1:0]         ypos_q, ypos_d;
    logic [POS_W-1:0]         vy_q, vy_d;
    logic [POS_W:0]           aim_sum;
    logic signed [POS_W+1:0]  aim_s;
    logic [POS_W-1:0]         target;
    logic [POS_W:0]           xdiff;
    logic [POS_W-1:0]         ball_dx;
    logic                     ball_right;
    logic                     trigger;
    logic signed [POS_W:0]    rise_y;
    logic [POS_W:0]           fall_y;

`ifdef AI_JITTER_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else if (tick) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign aim_s = $signed({1'b0, aim_sum}) + (POS_W+2)'($signed(lfsr_q[3:0]));
`else
    assign aim_s = $signed({1'b0, aim_sum});
`endif

    assign aim_sum    = {1'b0, ball_xpos} + (POS_W+1)'(AIM_OFFSET);
    assign ball_right = enable && (ball_xpos >= NET_XL);
    assign target     = ball_right ? clamp_x(aim_s) : HOME_XL;
    assign ball_dx    = (ball_xpos >= xpos_q) ? (ball_xpos - xpos_q) : (xpos_q - ball_xpos);
    assign trigger    = ball_right && (ball_dx <= JUMP_DXL) &&
                        (ball_ypos >= Y_HIL) && (ball_ypos <= Y_LOL);
    assign rise_y     = $signed({1'b0, ypos_q}) - $signed({1'b0, vy_q});
    assign fall_y     = {1'b0, ypos_q} + {1'b0, vy_q} + {1'b0, GRAVITYL};

    always_comb begin
        state_d = state_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        vy_d    = vy_q;
        xdiff   = '0;
        if (tick) begin
            // Horizontal walk toward the target, independent of jump state.
            if (target >= xpos_q) begin
                xdiff  = {1'b0, target} - {1'b0, xpos_q};
                xpos_d = (xdiff <= STEPL) ? target : xpos_q + POS_W'(STEP);
            end else begin
                xdiff  = {1'b0, xpos_q} - {1'b0, target};
                xpos_d = (xdiff <= STEPL) ? target : xpos_q - POS_W'(STEP);
            end

            unique case (state_q)
                GROUND: begin
                    if (trigger) begin
                        state_d = RISE;
                        vy_d    = JUMP_VL;
                    end
                end
                RISE: begin
                    ypos_d = (rise_y < 0) ? '0 : POS_W'(rise_y);
                    if (vy_q <= GRAVITYL) begin
                        state_d = FALL;
                        vy_d    = '0;
                    end else begin
                        vy_d = vy_q - GRAVITYL;
                    end
                end
                FALL: begin
                    if (fall_y >= {1'b0, GROUND_YL}) begin
                        ypos_d  = GROUND_YL;
                        state_d = GROUND;
                        vy_d    = '0;
                    end else begin
                        ypos_d = POS_W'(fall_y);
                        vy_d   = vy_q + GRAVITYL;
                    end
                end
                default: begin
                    state_d = GROUND;
                    ypos_d  = GROUND_YL;
                    vy_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q <= GROUND;
            xpos_q  <= HOME_XL;
            ypos_q  <= GROUND_YL;
            vy_q    <= '0;
        end else begin
            state_q <= state_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            vy_q    <= vy_d;
        end
    end

    assign xpos   = xpos_q;
    assign ypos   = ypos_q;
    assign in_air = (state_q != GROUND);

endmodule
